// File: rtl/drbg_sync_pkg.sv
// rtl/drbg_sync_pkg.sv - shared state encoding and sizing helpers for the DRBG sequence synchroniser
package drbg_sync_pkg;

    typedef enum logic [2:0] {
        ST_RESET_DRBG = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_IDLE       = 3'd2,
        ST_EVAL       = 3'd3,
        ST_CATCH_UP   = 3'd4,
        ST_HOLD       = 3'd5,
        ST_LOCKED     = 3'd6
    } state_t;

    localparam int DEF_SEQ_W        = 32;
    localparam int DEF_AHEAD_THRESH = 60;
    localparam int DEF_RST_CYCLES   = 4;
    localparam int DEF_STEP_TIMEOUT = 256;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_diff_cmp.sv
// rtl/seq_diff_cmp.sv - wrap-aware signed comparison of target vs internal sequence number
module seq_diff_cmp
    import drbg_sync_pkg::*;
#(
    parameter int SEQ_W        = DEF_SEQ_W,
    parameter int AHEAD_THRESH = DEF_AHEAD_THRESH
) (
    input  logic [SEQ_W-1:0] i_target,
    input  logic [SEQ_W-1:0] i_internal,
    output logic             o_eq,
    output logic             o_behind,
    output logic             o_ahead_small,
    output logic             o_ahead_large
);

    localparam logic [SEQ_W-1:0] THRESH = SEQ_W'(AHEAD_THRESH);

    logic [SEQ_W-1:0] w_diff;
    logic [SEQ_W-1:0] w_neg;

    // Most-negative diff negates to itself and lands in ahead_large via the unsigned compare.
    assign w_diff        = i_target - i_internal;
    assign w_neg         = -w_diff;
    assign o_eq          = (w_diff == '0);
    assign o_behind      = !w_diff[SEQ_W-1] && !o_eq;
    assign o_ahead_small = w_diff[SEQ_W-1] && (w_neg <= THRESH);
    assign o_ahead_large = w_diff[SEQ_W-1] && !o_ahead_small;

endmodule

// File: rtl/drbg_sync_controller.sv
// rtl/drbg_sync_controller.sv - steers the slave hash-DRBG to the recovered stream sequence number
// Optional DRBG_SYNC_STATS_EN adds resync_count and step_count outputs.
module drbg_sync_controller
    import drbg_sync_pkg::*;
#(
    parameter int SEQ_W        = DEF_SEQ_W,
    parameter int AHEAD_THRESH = DEF_AHEAD_THRESH,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEQ_W-1:0] sequence_internal,
    input  logic             init_done,
    input  logic [SEQ_W-1:0] sequence_external,
    input  logic             sequence_external_valid,
    input  logic             V,
    output logic             reset_n_drbg,
    output logic             catch_up_mode,
    output logic             get_next_seed,
    output logic             block_drbg_reseed,
    output logic             locked,
    output logic             sync_error
`ifdef DRBG_SYNC_STATS_EN
    ,
    output logic [15:0]      resync_count,
    output logic [SEQ_W-1:0] step_count
`endif
);

    localparam int RC_W = cnt_width(RST_CYCLES);
    localparam int TO_W = cnt_width(STEP_TIMEOUT);

    state_t           r_state;
    logic [SEQ_W-1:0] r_tgt;
    logic             r_tgt_valid;
    logic [SEQ_W-1:0] r_prev_int;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [TO_W-1:0]  r_timer;

    logic [SEQ_W-1:0] w_new_tgt;
    logic [SEQ_W-1:0] w_cmp_tgt;
    logic             w_eq, w_behind, w_ahead_small, w_ahead_large;
    logic             w_step_seen;
    logic             w_in_init;

    assign w_new_tgt   = V ? sequence_external : sequence_external - SEQ_W'(1);
    // A strobe arriving in the decision cycle wins over the held target.
    assign w_cmp_tgt   = sequence_external_valid ? w_new_tgt : r_tgt;
    assign w_step_seen = (sequence_internal != r_prev_int);
    assign w_in_init   = (r_state == ST_RESET_DRBG) || (r_state == ST_WAIT_INIT);

    seq_diff_cmp #(
        .SEQ_W        (SEQ_W),
        .AHEAD_THRESH (AHEAD_THRESH)
    ) u_cmp (
        .i_target      (w_cmp_tgt),
        .i_internal    (sequence_internal),
        .o_eq          (w_eq),
        .o_behind      (w_behind),
        .o_ahead_small (w_ahead_small),
        .o_ahead_large (w_ahead_large)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_RESET_DRBG;
            r_tgt             <= '0;
            r_tgt_valid       <= 1'b0;
            r_prev_int        <= '0;
            r_rst_cnt         <= RC_W'(RST_CYCLES);
            r_timer           <= '0;
            reset_n_drbg      <= 1'b0;
            catch_up_mode     <= 1'b0;
            get_next_seed     <= 1'b0;
            block_drbg_reseed <= 1'b0;
            locked            <= 1'b0;
            sync_error        <= 1'b0;
`ifdef DRBG_SYNC_STATS_EN
            resync_count      <= '0;
            step_count        <= '0;
`endif
        end else begin
            get_next_seed <= 1'b0;
            sync_error    <= 1'b0;
`ifdef DRBG_SYNC_STATS_EN
            if (get_next_seed)
                step_count <= step_count + SEQ_W'(1);
`endif
            if (sequence_external_valid) begin
                r_tgt       <= w_new_tgt;
                r_tgt_valid <= 1'b1;
            end

            if (!init_done && !w_in_init) begin
                r_state           <= ST_WAIT_INIT;
                catch_up_mode     <= 1'b0;
                block_drbg_reseed <= 1'b0;
                locked            <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET_DRBG: begin
                        if (r_rst_cnt <= RC_W'(1)) begin
                            r_state      <= ST_WAIT_INIT;
                            reset_n_drbg <= 1'b1;
                        end else begin
                            r_rst_cnt <= r_rst_cnt - RC_W'(1);
                        end
                    end
                    ST_WAIT_INIT: begin
                        if (init_done)
                            r_state <= (r_tgt_valid || sequence_external_valid) ? ST_EVAL : ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (sequence_external_valid)
                            r_state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        if (w_eq) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else if (w_behind) begin
                            r_state       <= ST_CATCH_UP;
                            catch_up_mode <= 1'b1;
                            get_next_seed <= 1'b1;
                            r_prev_int    <= sequence_internal;
                            r_timer       <= '0;
                        end else if (w_ahead_small) begin
                            r_state           <= ST_HOLD;
                            block_drbg_reseed <= 1'b1;
                        end else begin
                            r_state      <= ST_RESET_DRBG;
                            r_rst_cnt    <= RC_W'(RST_CYCLES);
                            reset_n_drbg <= 1'b0;
`ifdef DRBG_SYNC_STATS_EN
                            if (resync_count != 16'hFFFF)
                                resync_count <= resync_count + 16'd1;
`endif
                        end
                    end
                    ST_CATCH_UP: begin
                        if (w_step_seen) begin
                            if (w_eq) begin
                                r_state       <= ST_LOCKED;
                                catch_up_mode <= 1'b0;
                                locked        <= 1'b1;
                            end else if (w_behind) begin
                                get_next_seed <= 1'b1;
                                r_prev_int    <= sequence_internal;
                                r_timer       <= '0;
                            end else begin
                                r_state       <= ST_EVAL;
                                catch_up_mode <= 1'b0;
                            end
                        end else if (r_timer == TO_W'(STEP_TIMEOUT - 1)) begin
                            sync_error    <= 1'b1;
                            r_state       <= ST_RESET_DRBG;
                            r_rst_cnt     <= RC_W'(RST_CYCLES);
                            reset_n_drbg  <= 1'b0;
                            catch_up_mode <= 1'b0;
`ifdef DRBG_SYNC_STATS_EN
                            if (resync_count != 16'hFFFF)
                                resync_count <= resync_count + 16'd1;
`endif
                        end else begin
                            r_timer <= r_timer + TO_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (sequence_external_valid && (w_eq || w_behind)) begin
                            r_state           <= ST_EVAL;
                            block_drbg_reseed <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        if (sequence_external_valid) begin
                            r_state <= ST_EVAL;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_RESET_DRBG;
                        r_rst_cnt    <= RC_W'(RST_CYCLES);
                        reset_n_drbg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drbg_sync_controller.sv
// tb/tb_drbg_sync_controller.sv - self-checking bench with a behavioural slave DRBG and lock scoreboard
`timescale 1ns/1ps
module tb_drbg_sync_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] seq_int = 32'd0;
    logic        init_done = 1'b0;
    logic [31:0] seq_ext = 32'd0;
    logic        ext_valid = 1'b0;
    logic        v = 1'b0;
    logic        reset_n_drbg, catch_up_mode, get_next_seed, block_drbg_reseed, locked, sync_error;
`ifdef DRBG_SYNC_STATS_EN
    logic [15:0] resync_count;
    logic [31:0] step_count;
`endif

    // Behavioural DRBG controls driven from the stimulus tasks
    logic        m_load = 1'b0;
    logic [31:0] m_load_val = 32'd0;
    logic [31:0] m_reset_val = 32'd1;
    logic        m_step_en = 1'b1;
    logic        m_reseed = 1'b0;
    int          m_icnt = 0;

    int gns_total = 0;
    int err_total = 0;
    int reinit_total = 0;
    logic prev_rnd = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    drbg_sync_controller dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .sequence_internal       (seq_int),
        .init_done               (init_done),
        .sequence_external       (seq_ext),
        .sequence_external_valid (ext_valid),
        .V                       (v),
        .reset_n_drbg            (reset_n_drbg),
        .catch_up_mode           (catch_up_mode),
        .get_next_seed           (get_next_seed),
        .block_drbg_reseed       (block_drbg_reseed),
        .locked                  (locked),
        .sync_error              (sync_error)
`ifdef DRBG_SYNC_STATS_EN
        ,
        .resync_count            (resync_count),
        .step_count              (step_count)
`endif
    );

    always @(posedge clk) begin
        if (m_load) begin
            seq_int <= m_load_val;
        end else if (!reset_n_drbg) begin
            seq_int   <= m_reset_val;
            init_done <= 1'b0;
            m_icnt    <= 0;
        end else begin
            if (!init_done) begin
                m_icnt <= m_icnt + 1;
                if (m_icnt == 2) init_done <= 1'b1;
            end
            if (init_done && ((get_next_seed && m_step_en) || (m_reseed && !block_drbg_reseed)))
                seq_int <= seq_int + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (get_next_seed) gns_total++;
        if (sync_error) err_total++;
        if (prev_rnd && !reset_n_drbg) reinit_total++;
        prev_rnd = reset_n_drbg;
    end

    task automatic strobe(input logic [31:0] ext, input logic vv);
        @(posedge clk); #1;
        seq_ext = ext; v = vv; ext_valid = 1'b1;
        @(posedge clk); #1;
        ext_valid = 1'b0;
    endtask

    task automatic load_int(input logic [31:0] val);
        @(posedge clk); #1;
        m_load = 1'b1; m_load_val = val;
        @(posedge clk); #1;
        m_load = 1'b0;
    endtask

    task automatic wait_lock(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (locked) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        int lows;
        int g0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({reset_n_drbg, catch_up_mode, get_next_seed, block_drbg_reseed, locked, sync_error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                {reset_n_drbg, catch_up_mode, get_next_seed, block_drbg_reseed, locked, sync_error});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reset_n_drbg) break;
            lows++;
        end
        checks++;
        if (lows != 4) begin
            failures++;
            $display("FAIL reset_hold_cycles got=%0d want=4", lows);
        end
        g0 = gns_total;
        repeat (15) @(negedge clk);
        checks++;
        if (locked !== 1'b0 || catch_up_mode !== 1'b0 || gns_total != g0 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL idle_no_target locked=%b catch=%b steps=%0d init=%b want 0 0 0 1",
                locked, catch_up_mode, gns_total - g0, init_done);
        end
    endtask

    task automatic test_catch_up();
        int g0, e0;
        bit ok;
        logic [31:0] exp;
        load_int(32'd10);
        g0 = gns_total;
        sb.push_back(32'd19);
        strobe(32'd20, 1'b0);
        wait_lock(200, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp) begin
            failures++;
            $display("FAIL catchup_lock locked=%b internal=%0d want locked at %0d", locked, seq_int, exp);
        end
        checks++;
        if (gns_total - g0 != 9 || catch_up_mode !== 1'b0) begin
            failures++;
            $display("FAIL catchup_steps got=%0d catch=%b want=9 catch=0", gns_total - g0, catch_up_mode);
        end
        g0 = gns_total;
        sb.push_back(32'd29);
        strobe(32'd29, 1'b1);
        wait_lock(200, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp || gns_total - g0 != 10) begin
            failures++;
            $display("FAIL catchup_v1 internal=%0d steps=%0d want %0d steps=10", seq_int, gns_total - g0, exp);
        end
        g0 = gns_total;
        e0 = err_total;
        sb.push_back(32'd89);
        strobe(32'd89, 1'b1);
        wait_lock(600, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp || gns_total - g0 != 60 || err_total != e0) begin
            failures++;
            $display("FAIL catchup_60 internal=%0d steps=%0d errs=%0d want %0d steps=60 errs=0",
                seq_int, gns_total - g0, err_total - e0, exp);
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic [31:0] exp;
        strobe(32'd88, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (block_drbg_reseed !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL hold_block block=%b locked=%b want 1 0", block_drbg_reseed, locked);
        end
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            m_reseed = ~m_reseed;
        end
        m_reseed = 1'b0;
        @(negedge clk);
        checks++;
        if (seq_int !== 32'd89) begin
            failures++;
            $display("FAIL hold_frozen internal=%0d want=89", seq_int);
        end
        sb.push_back(32'd89);
        strobe(32'd89, 1'b1);
        wait_lock(3, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp || block_drbg_reseed !== 1'b0) begin
            failures++;
            $display("FAIL hold_release locked=%b internal=%0d block=%b want 1 %0d 0",
                locked, seq_int, block_drbg_reseed, exp);
        end
    endtask

    task automatic test_reinit();
        int lows, g0;
        bit ok;
        bit seen;
        logic [31:0] exp;
        m_reset_val = 32'd1;
        g0 = gns_total;
        sb.push_back(32'd28);
        strobe(32'd28, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!reset_n_drbg) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        lows = 0;
        for (int i = 0; i < 20 && seen; i++) begin
            if (reset_n_drbg) break;
            lows++;
            @(negedge clk);
        end
        checks++;
        if (!seen || lows != 4) begin
            failures++;
            $display("FAIL reinit_hold seen=%b low_cycles=%0d want 1 4", seen, lows);
        end
        wait_lock(300, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp || gns_total - g0 != 27) begin
            failures++;
            $display("FAIL reinit_catchup internal=%0d steps=%0d want %0d steps=27", seq_int, gns_total - g0, exp);
        end
    endtask

    task automatic test_wrap();
        int g0, r0;
        bit ok;
        logic [31:0] exp;
        load_int(32'hFFFF_FFFE);
        g0 = gns_total;
        r0 = reinit_total;
        sb.push_back(32'h0000_0001);
        strobe(32'h0000_0001, 1'b1);
        wait_lock(100, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp || gns_total - g0 != 3 || reinit_total != r0) begin
            failures++;
            $display("FAIL wrap internal=%h steps=%0d reinits=%0d want %h steps=3 reinits=0",
                seq_int, gns_total - g0, reinit_total - r0, exp);
        end
    endtask

    task automatic test_timeout();
        int n, g0;
        bit seen, ok;
        logic [31:0] exp;
        m_step_en = 1'b0;
        strobe(32'd10, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (get_next_seed) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n = 0;
        for (int i = 0; i < 300 && seen; i++) begin
            @(negedge clk);
            n++;
            if (sync_error) break;
        end
        checks++;
        if (!seen || sync_error !== 1'b1 || n != 256 || reset_n_drbg !== 1'b0) begin
            failures++;
            $display("FAIL step_timeout step=%b err=%b cycles=%0d rst_drbg=%b want 1 1 256 0",
                seen, sync_error, n, reset_n_drbg);
        end
        m_step_en = 1'b1;
        sb.push_back(32'd10);
        wait_lock(300, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || seq_int !== exp) begin
            failures++;
            $display("FAIL timeout_recover locked=%b internal=%0d want 1 %0d", locked, seq_int, exp);
        end
        strobe(32'd1000, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({reset_n_drbg, catch_up_mode, get_next_seed, block_drbg_reseed, locked, sync_error} !== 6'b0) begin
            failures++;
            $display("FAIL async_abort got=%b want=000000",
                {reset_n_drbg, catch_up_mode, get_next_seed, block_drbg_reseed, locked, sync_error});
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        g0 = gns_total;
        repeat (30) @(negedge clk);
        checks++;
        if (gns_total != g0 || catch_up_mode !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL target_discarded steps=%0d catch=%b locked=%b want 0 0 0",
                gns_total - g0, catch_up_mode, locked);
        end
    endtask

    initial begin
        test_reset();
        test_catch_up();
        test_hold();
        test_reinit();
        test_wrap();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
